// File: rtl/lc3b_evict_buffer_if.sv
// LC-3b evict buffer bus: L1 eviction handshake, L2 write port, lookup port.
interface lc3b_evict_buffer_if;
   logic         evict_req;
   logic [11:0]  evict_tag;
   logic [127:0] evict_data;
   logic         evict_ack;
   logic         l2_write;
   logic [15:0]  l2_address;
   logic [127:0] l2_wdata;
   logic         l2_resp;
   logic [11:0]  lookup_tag;
   logic         lookup_hit;
   logic [127:0] lookup_data;
   logic         full;
   logic         empty;

   modport master (
      output evict_req, evict_tag, evict_data,
      output l2_resp, lookup_tag,
      input  evict_ack, l2_write, l2_address, l2_wdata,
      input  lookup_hit, lookup_data, full, empty
   );

   modport slave (
      input  evict_req, evict_tag, evict_data,
      input  l2_resp, lookup_tag,
      output evict_ack, l2_write, l2_address, l2_wdata,
      output lookup_hit, lookup_data, full, empty
   );
endinterface

// File: rtl/lc3b_evict_buffer.sv
// LC-3b dirty-line evict FIFO draining to L2, with write coalescing.
// Define LC3B_EVICT_FWD_EN to enable lookup forwarding of buffered lines.
module lc3b_evict_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   lc3b_evict_buffer_if.slave   bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] WRITE = 1'b1;

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [11:0]      tag_q  [DEPTH];
   logic [127:0]     data_q [DEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [0:0]       state_q, state_d;

   logic          full, empty;
   logic          co_hit, push, pop, ack;
   logic [PW-1:0] co_idx;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

   // The head is locked while its L2 write is in flight.
   always_comb begin
      co_hit = 1'b0;
      co_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && tag_q[i] == bus.evict_tag &&
             !(PW'(i) == head_q && state_q == WRITE)) begin
            co_hit = 1'b1;
            co_idx = PW'(i);
         end
      end
   end

   assign ack  = bus.evict_req & ~reset & (co_hit | ~full);
   assign push = bus.evict_req & ~reset & ~co_hit & ~full;
   assign pop  = (state_q == WRITE) & bus.l2_resp;

   always_comb begin
      valid_d = valid_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (push) begin
         valid_d[tail_q] = 1'b1;
         tail_d          = tail_q + 1'b1;
      end
      if (pop) begin
         valid_d[head_q] = 1'b0;
         head_d          = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Looking at next occupancy lets a fresh push start its write next cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (count_d != '0) state_d = WRITE;
         WRITE:   if (bus.l2_resp)   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= IDLE;
      end else begin
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         if (push) begin
            tag_q[tail_q]  <= bus.evict_tag;
            data_q[tail_q] <= bus.evict_data;
         end else if (ack) begin
            data_q[co_idx] <= bus.evict_data;
         end
      end
   end

   assign bus.evict_ack  = ack;
   assign bus.full       = full;
   assign bus.empty      = empty;
   assign bus.l2_write   = (state_q == WRITE);
   assign bus.l2_address = {tag_q[head_q], 4'b0000};
   assign bus.l2_wdata   = data_q[head_q];

`ifdef LC3B_EVICT_FWD_EN
   logic [PW-1:0] lk_idx;
   logic          lk_hit;
   logic [127:0]  lk_data;

   // Scan oldest to youngest so the youngest match wins.
   always_comb begin
      lk_idx  = '0;
      lk_hit  = 1'b0;
      lk_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         lk_idx = head_q + PW'(k);
         if (valid_q[lk_idx] && tag_q[lk_idx] == bus.lookup_tag) begin
            lk_hit  = 1'b1;
            lk_data = data_q[lk_idx];
         end
      end
   end

   assign bus.lookup_hit  = lk_hit;
   assign bus.lookup_data = lk_data;
`else
   // L1 must stall misses until the buffer is empty.
   logic unused_lookup;
   assign unused_lookup   = ^bus.lookup_tag;
   assign bus.lookup_hit  = 1'b0;
   assign bus.lookup_data = '0;
`endif
endmodule

// File: tb/tb_lc3b_evict_buffer.sv
// Directed bench for lc3b_evict_buffer (DEPTH=4), both forwarding builds.
module tb_lc3b_evict_buffer;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

`ifdef LC3B_EVICT_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   lc3b_evict_buffer_if bus ();

   lc3b_evict_buffer #(.DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         req;
      logic [11:0]  tag;
      logic [127:0] data;
      logic         resp;
      logic [11:0]  ltag;
      logic         ack;
      logic         emp;
      logic         ful;
      logic         l2w;
      logic [15:0]  addr;
      logic [127:0] wd;
      logic         hit;
      logic [127:0] ld;
   } vec_t;

   vec_t tbl [18];

   function automatic logic [127:0] d(input logic [15:0] n);
      return {8{n}};
   endfunction

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic setin(input logic req, input logic [11:0] tag,
                        input logic [127:0] data, input logic resp,
                        input logic [11:0] ltag);
      bus.evict_req  = req;
      bus.evict_tag  = tag;
      bus.evict_data = data;
      bus.l2_resp    = resp;
      bus.lookup_tag = ltag;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      setin(1'b0, '0, '0, 1'b0, '0);
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic drain_expect(input logic [15:0] addr,
                               input logic [127:0] data);
      int n;
      n = 0;
      while (bus.l2_write !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      check("drain_wr", bus.l2_write, 1'b1);
      check("drain_addr", bus.l2_address, addr);
      check("drain_data", bus.l2_wdata, data);
      bus.l2_resp = 1'b1;
      step();
      bus.l2_resp = 1'b0;
      #1;
      check("drain_gap", bus.l2_write, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{0, 12'h000, 0,        0, 12'h123, 0, 1, 0, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 12'h123, d(16'hA), 0, 12'h123, 1, 1, 0, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 12'h000, 0,        0, 12'h123, 0, 0, 0, 1,
                  16'h1230, d(16'hA), 1, d(16'hA)};
      tbl[3]  = '{0, 12'h000, 0,        1, 12'h123, 0, 0, 0, 1,
                  16'h1230, d(16'hA), 1, d(16'hA)};
      tbl[4]  = '{0, 12'h000, 0,        0, 12'h123, 0, 1, 0, 0, 0, 0, 0, 0};
      tbl[5]  = '{1, 12'h001, d(16'h1), 0, 12'h0AB, 1, 1, 0, 0, 0, 0, 0, 0};
      tbl[6]  = '{1, 12'h002, d(16'h2), 0, 12'h0AB, 1, 0, 0, 1,
                  16'h0010, d(16'h1), 0, 0};
      tbl[7]  = '{1, 12'h003, d(16'h3), 0, 12'h001, 1, 0, 0, 1,
                  16'h0010, d(16'h1), 1, d(16'h1)};
      tbl[8]  = '{1, 12'h004, d(16'h4), 0, 12'h0AB, 1, 0, 0, 1,
                  16'h0010, d(16'h1), 0, 0};
      tbl[9]  = '{1, 12'h005, d(16'h5), 0, 12'h004, 0, 0, 1, 1,
                  16'h0010, d(16'h1), 1, d(16'h4)};
      tbl[10] = '{1, 12'h005, d(16'h5), 1, 12'h005, 0, 0, 1, 1,
                  16'h0010, d(16'h1), 0, 0};
      tbl[11] = '{1, 12'h005, d(16'h5), 0, 12'h001, 1, 0, 0, 0, 0, 0, 0, 0};
      tbl[12] = '{0, 12'h000, 0,        0, 12'h003, 0, 0, 1, 1,
                  16'h0020, d(16'h2), 1, d(16'h3)};
      tbl[13] = '{1, 12'h003, d(16'h33), 0, 12'h003, 1, 0, 1, 1,
                  16'h0020, d(16'h2), 1, d(16'h3)};
      tbl[14] = '{1, 12'h002, d(16'h22), 0, 12'h003, 0, 0, 1, 1,
                  16'h0020, d(16'h2), 1, d(16'h33)};
      tbl[15] = '{0, 12'h000, 0,        1, 12'h002, 0, 0, 1, 1,
                  16'h0020, d(16'h2), 1, d(16'h2)};
      tbl[16] = '{1, 12'h003, d(16'h333), 0, 12'h002, 1, 0, 0, 0,
                  0, 0, 0, 0};
      tbl[17] = '{0, 12'h000, 0,        0, 12'h003, 0, 0, 0, 1,
                  16'h0030, d(16'h333), 1, d(16'h333)};

      do_reset();
      for (int i = 0; i < 18; i++) begin
         setin(tbl[i].req, tbl[i].tag, tbl[i].data, tbl[i].resp,
               tbl[i].ltag);
         #1;
         check($sformatf("v%0d_ack", i), bus.evict_ack, tbl[i].ack);
         check($sformatf("v%0d_empty", i), bus.empty, tbl[i].emp);
         check($sformatf("v%0d_full", i), bus.full, tbl[i].ful);
         check($sformatf("v%0d_l2w", i), bus.l2_write, tbl[i].l2w);
         if (tbl[i].l2w) begin
            check($sformatf("v%0d_addr", i), bus.l2_address, tbl[i].addr);
            check($sformatf("v%0d_wdata", i), bus.l2_wdata, tbl[i].wd);
         end
         check($sformatf("v%0d_hit", i), bus.lookup_hit, FWD & tbl[i].hit);
         check($sformatf("v%0d_ldata", i), bus.lookup_data,
               FWD ? tbl[i].ld : 128'h0);
         step();
      end

      // Locked head duplicate, coalescing, youngest-wins lookup, drain order.
      do_reset();
      setin(1'b1, 12'h001, d(16'hB1), 1'b0, 12'h001);
      #1;
      check("A_ack1", bus.evict_ack, 1'b1);
      step();
      setin(1'b1, 12'h001, d(16'hB2), 1'b0, 12'h001);
      #1;
      check("A_wr", bus.l2_write, 1'b1);
      check("A_ack_dup", bus.evict_ack, 1'b1);
      step();
      setin(1'b1, 12'h002, d(16'hC1), 1'b0, 12'h001);
      step();
      setin(1'b1, 12'h002, d(16'hC2), 1'b0, 12'h001);
      #1;
      check("A_coal_ack", bus.evict_ack, 1'b1);
      step();
      setin(1'b1, 12'h0AA, d(16'hD), 1'b0, 12'h001);
      #1;
      check("A_ack_aa", bus.evict_ack, 1'b1);
      check("A_not_full", bus.full, 1'b0);
      step();
      setin(1'b0, 12'h000, 0, 1'b0, 12'h001);
      #1;
      check("A_full", bus.full, 1'b1);
      check("A_hit_young", bus.lookup_hit, FWD);
      check("A_data_young", bus.lookup_data, FWD ? d(16'hB2) : 128'h0);
      bus.lookup_tag = 12'h0AA;
      #1;
      check("A_hit_aa", bus.lookup_hit, FWD);
      check("A_data_aa", bus.lookup_data, FWD ? d(16'hD) : 128'h0);
      bus.lookup_tag = 12'h0AB;
      #1;
      check("A_hit_ab", bus.lookup_hit, 1'b0);
      check("A_data_ab", bus.lookup_data, 128'h0);
      drain_expect(16'h0010, d(16'hB1));
      drain_expect(16'h0010, d(16'hB2));
      drain_expect(16'h0020, d(16'hC2));
      drain_expect(16'h0AA0, d(16'hD));
      check("A_empty", bus.empty, 1'b1);

      // Reset during a write with l2_resp around it.
      do_reset();
      setin(1'b1, 12'h050, d(16'h50), 1'b0, 12'h050);
      step();
      setin(1'b0, 12'h000, 0, 1'b0, 12'h050);
      #1;
      check("B_wr", bus.l2_write, 1'b1);
      reset = 1'b1;
      setin(1'b1, 12'h060, d(16'h60), 1'b1, 12'h050);
      #1;
      check("B_ack_rst", bus.evict_ack, 1'b0);
      step();
      reset = 1'b0;
      setin(1'b0, 12'h000, 0, 1'b1, 12'h050);
      #1;
      check("B_empty", bus.empty, 1'b1);
      check("B_l2w", bus.l2_write, 1'b0);
      check("B_full", bus.full, 1'b0);
      check("B_hit", bus.lookup_hit, 1'b0);
      step();
      bus.l2_resp = 1'b0;
      #1;
      check("B_empty2", bus.empty, 1'b1);
      check("B_l2w2", bus.l2_write, 1'b0);
      step();
      check("B_empty3", bus.empty, 1'b1);
      check("B_full3", bus.full, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
